mem_access_stage: RTL and testbench

- Memory-access stage directly downstream of the EX/MEM pipeline register; consumes its outputs (ALU result, rt store data, destination register, control bits, NPC).
- Runs word loads and stores on a variable-latency data-memory bus with a req/ack handshake.
- Stalls the upstream pipeline while an access is outstanding.
- Contains the MEM/WB pipeline register and produces write-back data, destination and write enable for the WB stage.

---
 rtl/mem_access_stage.sv | 142 ++++++++++++++
 tb/tb_mem_access_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// Memory-access stage: drives a req/ack data bus for word loads and stores, stalls upstream while
// an access is outstanding, and holds the MEM/WB register. Optional: MEM_ACCESS_ALIGN_CHK_EN.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] NPC_IN,
    input  logic [31:0] ALU_C_IN,
    input  logic [31:0] RT_DATA_IN,
    input  logic [4:0]  reg_rd_in,
    input  logic        MEMR_IN,
    input  logic        MEMW_IN,
    input  logic        REGW_IN,
    input  logic        MEM2R_IN,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic        mem_stall,
    output logic        bus_err,
    output logic        align_err,
    output logic [31:0] NPC_OUT,
    output logic [31:0] WB_DATA_OUT,
    output logic [4:0]  reg_rd_out,
    output logic        REGW_OUT
);

    typedef enum logic {IDLE, REQ} state_t;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic             mem_op, misaligned, timeout_hit;
    logic             start, done, abort, misalign_hit;

    assign mem_op = MEMR_IN | MEMW_IN;

`ifdef MEM_ACCESS_ALIGN_CHK_EN
    assign misaligned = (ALU_C_IN[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        mem_stall    = 1'b0;
        start        = 1'b0;
        done         = 1'b0;
        abort        = 1'b0;
        misalign_hit = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    if (misaligned) begin
                        misalign_hit = 1'b1;
                    end else begin
                        start     = 1'b1;
                        mem_stall = 1'b1;
                        state_nx  = REQ;
                    end
                end
            end
            REQ: begin
                // ack takes priority over a coincident timeout
                if (dmem_ack) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end else if (timeout_hit) begin
                    abort    = 1'b1;
                    state_nx = IDLE;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_wdata  <= '0;
            bus_err     <= 1'b0;
            align_err   <= 1'b0;
            NPC_OUT     <= '0;
            WB_DATA_OUT <= '0;
            reg_rd_out  <= '0;
            REGW_OUT    <= 1'b0;
        end else begin
            bus_err   <= 1'b0;
            align_err <= 1'b0;
            if (start) begin
                // both MEMR and MEMW set resolves to a store via MEMW_IN
                dmem_req   <= 1'b1;
                dmem_we    <= MEMW_IN;
                dmem_addr  <= ALU_C_IN;
                dmem_wdata <= RT_DATA_IN;
                cnt        <= '0;
                REGW_OUT   <= 1'b0;
            end else if (done) begin
                dmem_req    <= 1'b0;
                NPC_OUT     <= NPC_IN;
                reg_rd_out  <= reg_rd_in;
                REGW_OUT    <= REGW_IN;
                WB_DATA_OUT <= MEM2R_IN ? dmem_rdata : ALU_C_IN;
            end else if (abort) begin
                dmem_req    <= 1'b0;
                bus_err     <= 1'b1;
                NPC_OUT     <= NPC_IN;
                reg_rd_out  <= reg_rd_in;
                WB_DATA_OUT <= ALU_C_IN;
                REGW_OUT    <= 1'b0;
            end else if (state == REQ) begin
                cnt      <= cnt + CNT_W'(1);
                REGW_OUT <= 1'b0;
            end else begin
                // plain ALU pass-through, or a misaligned access squashed to a bubble
                NPC_OUT     <= NPC_IN;
                reg_rd_out  <= reg_rd_in;
                WB_DATA_OUT <= ALU_C_IN;
                REGW_OUT    <= REGW_IN & ~misalign_hit;
                align_err   <= misalign_hit;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected MEM/WB writebacks are queued at issue time and
// popped by a monitor whenever REGW_OUT is presented; bus-side behaviour is checked directly.
module tb_mem_access_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] NPC_IN, ALU_C_IN, RT_DATA_IN, dmem_rdata;
    logic [4:0]  reg_rd_in;
    logic        MEMR_IN, MEMW_IN, REGW_IN, MEM2R_IN, dmem_ack;
    logic        dmem_req, dmem_we, mem_stall, bus_err, align_err, REGW_OUT;
    logic [31:0] dmem_addr, dmem_wdata, NPC_OUT, WB_DATA_OUT;
    logic [4:0]  reg_rd_out;

    mem_access_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(7)) dut (
        .clk(clk), .rst(rst),
        .NPC_IN(NPC_IN), .ALU_C_IN(ALU_C_IN), .RT_DATA_IN(RT_DATA_IN), .reg_rd_in(reg_rd_in),
        .MEMR_IN(MEMR_IN), .MEMW_IN(MEMW_IN), .REGW_IN(REGW_IN), .MEM2R_IN(MEM2R_IN),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .mem_stall(mem_stall), .bus_err(bus_err), .align_err(align_err),
        .NPC_OUT(NPC_OUT), .WB_DATA_OUT(WB_DATA_OUT), .reg_rd_out(reg_rd_out), .REGW_OUT(REGW_OUT)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] npc;
        logic [31:0] data;
        logic [4:0]  rd;
    } wb_t;

    wb_t exp_q[$];
    int  checks = 0;
    int  failures = 0;

    // running bus statistics; the main thread diffs snapshots around each access
    int          req_tot = 0, stall_tot = 0, addr_chg = 0;
    logic        prev_req = 1'b0;
    logic [31:0] prev_addr = '0, seen_addr = '0, seen_wdata = '0;
    logic        seen_we = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            req_tot   <= req_tot + int'(dmem_req);
            stall_tot <= stall_tot + int'(mem_stall);
            if (dmem_req && prev_req && dmem_addr != prev_addr) addr_chg <= addr_chg + 1;
            if (dmem_req) begin
                seen_addr  <= dmem_addr;
                seen_we    <= dmem_we;
                seen_wdata <= dmem_wdata;
            end
            prev_req  <= dmem_req;
            prev_addr <= dmem_addr;
        end
    end

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst && REGW_OUT) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wb_unexpected actual=REGW_OUT=1 npc=%h data=%h required=no writeback",
                         NPC_OUT, WB_DATA_OUT);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                chk("wb_npc", NPC_OUT, e.npc);
                chk("wb_data", WB_DATA_OUT, e.data);
                chk("wb_rd", {27'd0, reg_rd_out}, {27'd0, e.rd});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [31:0] alu, input logic [31:0] wd,
                         input logic [31:0] npc, input logic [4:0] rd, input logic regw, input logic m2r);
        MEMR_IN = r; MEMW_IN = w; ALU_C_IN = alu; RT_DATA_IN = wd;
        NPC_IN = npc; reg_rd_in = rd; REGW_IN = regw; MEM2R_IN = m2r;
    endtask

    task automatic nop();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    endtask

    // issue one access; ack_at = REQ cycle (1-based) carrying ack, 0 = never; n = REQ cycles driven
    task automatic access(input string tag, input int ack_at, input int n, input logic [31:0] rdata,
                          input int exp_req, input int exp_stall, input logic exp_berr);
        int r0, s0, a0;
        r0 = req_tot; s0 = stall_tot; a0 = addr_chg;
        for (int i = 0; i <= n; i++) begin
            if (ack_at != 0 && i == ack_at) begin
                dmem_ack = 1'b1;
                dmem_rdata = rdata;
            end
            step();
            dmem_ack = 1'b0;
        end
        nop();
        @(negedge clk);
        #1;
        chk({tag, "_req_cycles"}, req_tot - r0, exp_req);
        chk({tag, "_stall_cycles"}, stall_tot - s0, exp_stall);
        chk({tag, "_addr_stable"}, addr_chg - a0, 0);
        chk({tag, "_req_drop"}, {31'd0, dmem_req}, 32'd0);
        chk({tag, "_bus_err"}, {31'd0, bus_err}, {31'd0, exp_berr});
        step();
        @(negedge clk);
        chk({tag, "_bus_err_clear"}, {31'd0, bus_err}, 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        nop();
        #12;
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_wb", WB_DATA_OUT, 32'd0);
        chk("rst_regw", {31'd0, REGW_OUT}, 32'd0);
        chk("rst_stall", {31'd0, mem_stall}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // ALU ops, MEM2R ignored without an access
        drive(1'b0, 1'b0, 32'h1234, 32'h0, 32'h44, 5'd5, 1'b1, 1'b0);
        exp_q.push_back('{npc: 32'h44, data: 32'h1234, rd: 5'd5});
        #1 chk("alu_stall", {31'd0, mem_stall}, 32'd0);
        step();
        drive(1'b0, 1'b0, 32'hA5A5_0000, 32'h0, 32'h48, 5'd31, 1'b1, 1'b1);
        exp_q.push_back('{npc: 32'h48, data: 32'hA5A5_0000, rd: 5'd31});
        #1 chk("alu2_stall", {31'd0, mem_stall}, 32'd0);
        step();
        nop();
        step();

        // load, ack in the third REQ cycle
        drive(1'b1, 1'b0, 32'h100, 32'h0, 32'h50, 5'd7, 1'b1, 1'b1);
        exp_q.push_back('{npc: 32'h50, data: 32'hDEADBEEF, rd: 5'd7});
        access("load", 3, 3, 32'hDEADBEEF, 3, 3, 1'b0);
        chk("load_addr", seen_addr, 32'h100);
        chk("load_we", {31'd0, seen_we}, 32'd0);

        // store, ack in the first REQ cycle
        drive(1'b0, 1'b1, 32'h200, 32'hCAFEF00D, 32'h54, 5'd9, 1'b0, 1'b0);
        access("store", 1, 1, 32'h0, 1, 1, 1'b0);
        chk("store_addr", seen_addr, 32'h200);
        chk("store_we", {31'd0, seen_we}, 32'd1);
        chk("store_wdata", seen_wdata, 32'hCAFEF00D);

        // MEMR and MEMW together behave as a store
        drive(1'b1, 1'b1, 32'h204, 32'h1111_2222, 32'h58, 5'd3, 1'b0, 1'b0);
        access("rw", 2, 2, 32'h0, 2, 2, 1'b0);
        chk("rw_we", {31'd0, seen_we}, 32'd1);

        // timeout without ack
        drive(1'b1, 1'b0, 32'h300, 32'h0, 32'h5C, 5'd4, 1'b1, 1'b1);
        access("timeout", 0, TO, 32'h0, 4, 4, 1'b1);

        // ack in the last cycle before timeout completes normally
        drive(1'b1, 1'b0, 32'h304, 32'h0, 32'h60, 5'd6, 1'b1, 1'b1);
        exp_q.push_back('{npc: 32'h60, data: 32'h0BAD_F00D, rd: 5'd6});
        access("late_ack", TO, TO, 32'h0BAD_F00D, 4, 4, 1'b0);

        // load with MEM2R=0 writes back the ALU result
        drive(1'b1, 1'b0, 32'h308, 32'h0, 32'h64, 5'd8, 1'b1, 1'b0);
        exp_q.push_back('{npc: 32'h64, data: 32'h308, rd: 5'd8});
        access("m2r0", 1, 1, 32'h7777_7777, 1, 1, 1'b0);

        // stray ack while idle is ignored
        dmem_ack = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        step();
        dmem_ack = 1'b0;
        @(negedge clk);
        chk("idle_ack_req", {31'd0, dmem_req}, 32'd0);
        chk("idle_ack_regw", {31'd0, REGW_OUT}, 32'd0);

        // reset mid-access
        drive(1'b1, 1'b0, 32'h400, 32'h0, 32'h70, 5'd10, 1'b1, 1'b1);
        step();
        step();
        #1 chk("pre_rst_req", {31'd0, dmem_req}, 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_req", {31'd0, dmem_req}, 32'd0);
        chk("mid_rst_npc", NPC_OUT, 32'd0);
        chk("mid_rst_wb", WB_DATA_OUT, 32'd0);
        chk("mid_rst_addr", dmem_addr, 32'd0);
        nop();
        step();
        rst = 1'b1;
        step();
        drive(1'b0, 1'b0, 32'h9999, 32'h0, 32'h80, 5'd12, 1'b1, 1'b0);
        exp_q.push_back('{npc: 32'h80, data: 32'h9999, rd: 5'd12});
        step();
        nop();
        @(negedge clk);
        chk("post_rst_regw", {31'd0, REGW_OUT}, 32'd1);
        step();

`ifdef MEM_ACCESS_ALIGN_CHK_EN
        drive(1'b1, 1'b0, 32'h102, 32'h0, 32'h90, 5'd13, 1'b1, 1'b1);
        #1 chk("align_stall", {31'd0, mem_stall}, 32'd0);
        step();
        nop();
        @(negedge clk);
        chk("align_err", {31'd0, align_err}, 32'd1);
        chk("align_req", {31'd0, dmem_req}, 32'd0);
        chk("align_regw", {31'd0, REGW_OUT}, 32'd0);
        step();
        @(negedge clk);
        chk("align_err_clear", {31'd0, align_err}, 32'd0);
`else
        drive(1'b1, 1'b0, 32'h102, 32'h0, 32'h90, 5'd13, 1'b1, 1'b1);
        exp_q.push_back('{npc: 32'h90, data: 32'h5555_AAAA, rd: 5'd13});
        access("unaligned", 1, 1, 32'h5555_AAAA, 1, 1, 1'b0);
        chk("unaligned_addr", seen_addr, 32'h102);
        chk("unaligned_align_err", {31'd0, align_err}, 32'd0);
`endif

        step();
        step();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
